// File: rtl/serial_add8.sv
// Bit-serial adder: operands shift through one full-adder slice (two cascaded
// half-adders plus a carry flop) LSB-first; the result leaves on a valid/ready port.
module serial_add8 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             accept, last;
  logic             p, g, s, t, carry_nxt;

  // Full-adder slice built from two half-adders
  assign p         = a_sh[0] ^ b_sh[0];
  assign g         = a_sh[0] & b_sh[0];
  assign s         = p ^ carry;
  assign t         = p & carry;
  assign carry_nxt = g | t;
  assign last      = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Handshake outputs are decoded purely from the state register
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh  <= '0;
      b_sh  <= '0;
      cnt   <= '0;
      carry <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
    end else if (accept) begin
      a_sh  <= a;
      b_sh  <= b;
      cnt   <= '0;
      carry <= 1'b0;
    end else if (state == RUN) begin
      // sum fills from the MSB end so bit 0 lands at the LSB after WIDTH shifts
      a_sh  <= {1'b0, a_sh[WIDTH-1:1]};
      b_sh  <= {1'b0, b_sh[WIDTH-1:1]};
      sum   <= {s, sum[WIDTH-1:1]};
      carry <= carry_nxt;
      cnt   <= cnt + CW'(1);
      if (last) cout <= carry_nxt;
    end
  end

endmodule

// File: doc/serial_add8.md
# serial_add8

Bit-serial ripple adder that sits directly downstream of the half-adder cell. It accepts two WIDTH-bit operands over a valid/ready handshake and feeds them LSB-first, one bit per clock, through two cascaded half-adder stages plus a registered carry. It returns the full WIDTH-bit sum and carry-out over a second valid/ready handshake. This gives the chip multi-bit addition at the gate cost of a single full-adder slice.

## Interface
- WIDTH, 8, operand and sum width in bits; legal range 2..16.

- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- in_valid  input  1  operand pair a/b is presented
- in_ready  output  1  block can accept operands; high only in IDLE
- a  input  WIDTH  operand A, sampled on the accept edge only
- b  input  WIDTH  operand B, sampled on the accept edge only
- out_valid  output  1  sum/cout hold a completed result
- out_ready  input  1  downstream consumes the result
- sum  output  WIDTH  result bits (a+b) mod 2^WIDTH
- cout  output  1  carry out of bit WIDTH-1
- busy  output  1  high in RUN or DONE

## Operation
- Accept: a transfer occurs when in_valid && in_ready are both high at a clk edge (handshake sampled at the edge).
- Three states: IDLE, RUN and DONE.
- IDLE
  - in_ready=1, out_valid=0, busy=0.
  - On accept: load a and b into shift registers, clear the carry flop, load bit counter=0, go to RUN.
- RUN
  - in_ready=0, busy=1.
  - Each cycle, with a0/b0 the current LSBs of the shift registers and c the carry flop:
    - half-adder 1: p = a0^b0, g = a0&b0
    - half-adder 2: s = p^c, t = p&c
    - next carry = g|t
  - s shifts into the MSB end of the sum register (shift right). The a/b registers shift right. Counter increments.
  - When counter == WIDTH-1 on an edge, the final bit is processed on that edge, cout takes the final carry, and the state goes to DONE.
  - After WIDTH shifts, sum bit 0 sits at the LSB.
- DONE
  - out_valid=1, busy=1, in_ready=0.
  - sum and cout stay stable until out_valid && out_ready at an edge, then go to IDLE.
- Arithmetic: unsigned; {cout,sum} == a+b exactly; no saturation.
- Changes on a/b after the accept edge have no effect on the result in progress.
- in_valid outside IDLE is ignored (no queuing); upstream must hold it until in_ready.
- sum/cout keep the last result through IDLE until the next DONE overwrites them. Intermediate values during RUN are don't-care to consumers (qualify with out_valid).

## Timing
- Reset: on any edge with rst=1, all of the following take effect on that edge:
  - state = IDLE, counter = 0, carry = 0, sum = 0, cout = 0
  - out_valid = 0, busy = 0, in_ready = 1 (from the next cycle)
  - while rst=1, in_valid is ignored.
- Reset has priority over every other event, including mid-RUN and DONE.
  - An aborted operation never asserts out_valid.
- Latency: accept on edge E0; RUN occupies edges E1..E_WIDTH; out_valid is high in the cycle after E_WIDTH. That is WIDTH cycles from accept to out_valid.
- With out_ready tied high, DONE lasts exactly 1 cycle and in_ready returns the cycle after. Throughput is one result per WIDTH+2 cycles.
- Out-of-order events:
  - out_ready high while not DONE: ignored.
  - out_ready and in_valid high together in DONE: only the output transfer happens. The input is accepted no earlier than the next IDLE cycle.
- All outputs are registered or decoded from the state register only; there is no combinational path from inputs to outputs.

## Test plan
- Basic add, WIDTH=8: a=0x0F, b=0x01, out_ready=1 -> out_valid exactly 8 cycles after accept with sum=0x10, cout=0. in_ready low for 9 cycles.
- Carry chain:
  - 0xFF+0x01 -> sum=0x00, cout=1
  - 0xFF+0xFF -> sum=0xFE, cout=1
  - 0x00+0x00 -> sum=0x00, cout=0
- Backpressure: hold out_ready=0 for 5 cycles in DONE with in_valid=1 and a=0x55, b=0x22 presented -> sum/cout unchanged, in_ready=0, no accept. Raise out_ready -> IDLE, then 0x55+0x22 -> 0x77 accepted and computed.
- Reset mid-operation: assert rst for 1 cycle after 3 RUN bits of 0xAA+0x55 -> next cycle IDLE, in_ready=1, sum=0, cout=0, busy=0, and out_valid never rises for that operation.
- Operand hold: change a/b every cycle after accept of 0x12+0x34 -> result 0x46, cout=0.
- Random: 1000 back-to-back random pairs with random out_ready stalls -> every {cout,sum} equals a+b, in order. With no stalls, the accept-to-accept spacing is WIDTH+2 cycles.
